// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types for the UART receive frame path: the frame FSM state
//   encoding, the parity mode encoding and a helper that tells whether a
//   parity mode actually carries a parity bit on the line.
//   Optional feature macro used by the users of this package: UART_RX_CRC_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PAR,
    CRC,
    STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2,
    PARITY_RSVD = 2'd3
  } parity_mode_e;

  // The reserved encoding is treated exactly like "none".
  function automatic logic parity_active(input parity_mode_e mode);
    return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_crc_serial.sv
// uart_crc_serial
//   Bit-serial CRC accumulator (non-reflected, implicit x^CRC_W term).
//   One message bit is folded in per enabled cycle, in arrival order.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset, register returns to CRC_INIT
//   init_i  reload the seed CRC_INIT (wins over en_i)
//   en_i    fold bit_i into the running CRC
//   bit_i   message bit
//   crc_o   current CRC value
module uart_crc_serial
  import uart_pkg::*;
#(
  parameter int unsigned      CRC_W    = 8,
  parameter logic [CRC_W-1:0] CRC_POLY = 8'h07,
  parameter logic [CRC_W-1:0] CRC_INIT = 8'h00
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             init_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] crc_q;
  logic             feedback;

  assign feedback = crc_q[CRC_W-1] ^ bit_i;

  // Galois-style shift: the outgoing MSB xored with the new bit decides
  // whether the polynomial is folded back in.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= CRC_INIT;
    end else if (init_i) begin
      crc_q <= CRC_INIT;
    end else if (en_i) begin
      crc_q <= {crc_q[CRC_W-2:0], 1'b0} ^ (feedback ? CRC_POLY : '0);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/uart_rx_frame_path.sv
// uart_rx_frame_path
//   UART receive frame engine. Advances only on the mid-bit sample strobe,
//   deserialises DATA_W bits LSB-first, then checks either a parity bit or a
//   serial CRC field, then STOP_BITS stop bits. Good frames are presented on
//   a valid/ready port; errors and overruns are reported as 1-cycle pulses.
//   Optional feature macro: UART_RX_CRC_EN (builds the CRC field check).
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   rx_i, trigger_i      synchronised serial line, 1-cycle sample strobe
//   parity_mode_i        0 none, 1 even, 2 odd, 3 reserved (= none)
//   crc_en_i             CRC field replaces parity (only with UART_RX_CRC_EN)
//   sampled_start_o      start bit accepted this cycle (baud resync)
//   busy_o               frame in progress
//   data_o/data_valid_o  received word and its valid flag
//   data_ready_i         consumer accepts the word when valid & ready
//   parity_err_o, crc_err_o, frame_err_o, overrun_o   1-cycle pulses
module uart_rx_frame_path
  import uart_pkg::*;
#(
  parameter int unsigned      DATA_W    = 8,
  parameter int unsigned      STOP_BITS = 1,
  parameter int unsigned      CRC_W     = 8,
  parameter logic [CRC_W-1:0] CRC_POLY  = 8'h07,
  parameter logic [CRC_W-1:0] CRC_INIT  = 8'h00
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_i,
  input  logic              trigger_i,
  input  logic [1:0]        parity_mode_i,
  input  logic              crc_en_i,
  output logic              sampled_start_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  input  logic              data_ready_i,
  output logic              parity_err_o,
  output logic              crc_err_o,
  output logic              frame_err_o,
  output logic              overrun_o
);

  // One counter serves every multi-bit state, so it is sized for the longest.
  localparam int unsigned CNT_MAX = (DATA_W > CRC_W) ?
                                    ((DATA_W > STOP_BITS) ? DATA_W : STOP_BITS) :
                                    ((CRC_W > STOP_BITS) ? CRC_W : STOP_BITS);
  localparam int unsigned CNT_W = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_bit_q, par_bit_d;
  logic              stop_err_q, stop_err_d;
  parity_mode_e      par_mode_q, par_mode_d;
  logic              crc_mode_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              par_err_q, par_err_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              start_hit;
  logic              stop_bad;
  logic              par_bad;
  logic              crc_bad;

`ifdef UART_RX_CRC_EN
  localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC_W - 1);

  logic              crc_mode_d;
  logic [CRC_W-1:0]  crc_field_q, crc_field_d;
  logic [CRC_W-1:0]  crc_val;
  logic              crc_init;
  logic              crc_step;
  logic              crc_err_q, crc_err_d;

  // The CRC covers the data bits only, seeded when the start bit is taken.
  uart_crc_serial #(
    .CRC_W    (CRC_W),
    .CRC_POLY (CRC_POLY),
    .CRC_INIT (CRC_INIT)
  ) u_crc (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .init_i (crc_init),
    .en_i   (crc_step),
    .bit_i  (rx_i),
    .crc_o  (crc_val)
  );

  assign crc_bad   = crc_mode_q & (crc_val != crc_field_q);
  assign crc_err_o = crc_err_q;
`else
  logic unused_crc_cfg;

  assign unused_crc_cfg = ^{crc_en_i, CRC_POLY, CRC_INIT};
  assign crc_mode_q     = 1'b0;
  assign crc_bad        = 1'b0;
  assign crc_err_o      = 1'b0;
`endif

  // Frame checks evaluated on the last stop trigger. The current rx_i is the
  // final stop sample; parity is meaningless when a CRC field was received.
  assign stop_bad = stop_err_q | ~rx_i;
  assign par_bad  = ~crc_mode_q & parity_active(par_mode_q) &
                    ((^shift_q ^ par_bit_q) != (par_mode_q == PARITY_ODD));

  // Next-state and datapath: only strobe cycles move the frame along; the
  // output handshake and pulse clearing run every cycle.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_bit_d   = par_bit_q;
    stop_err_d  = stop_err_q;
    par_mode_d  = par_mode_q;
`ifdef UART_RX_CRC_EN
    crc_mode_d  = crc_mode_q;
    crc_field_d = crc_field_q;
    crc_init    = 1'b0;
    crc_step    = 1'b0;
    crc_err_d   = 1'b0;
`endif
    data_d      = data_q;
    valid_d     = valid_q & ~data_ready_i;
    par_err_d   = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    start_hit   = 1'b0;

    if (trigger_i) begin
      case (state_q)
        IDLE: begin
          if (!rx_i) begin
            start_hit  = 1'b1;
            state_d    = DATA;
            bit_cnt_d  = '0;
            stop_err_d = 1'b0;
            par_mode_d = parity_mode_e'(parity_mode_i);
`ifdef UART_RX_CRC_EN
            crc_mode_d = crc_en_i;
            crc_init   = 1'b1;
`endif
          end
        end

        DATA: begin
          shift_d = {rx_i, shift_q[DATA_W-1:1]};
`ifdef UART_RX_CRC_EN
          crc_step = 1'b1;
`endif
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            if (crc_mode_q) begin
              state_d = CRC;
            end else if (parity_active(par_mode_q)) begin
              state_d = PAR;
            end else begin
              state_d = STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end

        PAR: begin
          par_bit_d = rx_i;
          bit_cnt_d = '0;
          state_d   = STOP;
        end

        CRC: begin
`ifdef UART_RX_CRC_EN
          crc_field_d = {rx_i, crc_field_q[CRC_W-1:1]};
          if (bit_cnt_q == CRC_LAST) begin
            bit_cnt_d = '0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
`else
          state_d = IDLE;
`endif
        end

        STOP: begin
          if (bit_cnt_q == STOP_LAST) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            stop_err_d = 1'b0;
            // A word consumed in this very cycle frees the slot for the new one.
            if (stop_bad | par_bad | crc_bad) begin
              frame_err_d = stop_bad;
              par_err_d   = par_bad;
`ifdef UART_RX_CRC_EN
              crc_err_d   = crc_bad;
`endif
            end else if (valid_q & ~data_ready_i) begin
              overrun_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end else begin
            stop_err_d = stop_bad;
            bit_cnt_d  = bit_cnt_q + 1'b1;
          end
        end

        default: begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end
      endcase
    end
  end

  // Register file for the frame state and the registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_bit_q   <= 1'b0;
      stop_err_q  <= 1'b0;
      par_mode_q  <= PARITY_NONE;
`ifdef UART_RX_CRC_EN
      crc_mode_q  <= 1'b0;
      crc_field_q <= '0;
      crc_err_q   <= 1'b0;
`endif
      data_q      <= '0;
      valid_q     <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_bit_q   <= par_bit_d;
      stop_err_q  <= stop_err_d;
      par_mode_q  <= par_mode_d;
`ifdef UART_RX_CRC_EN
      crc_mode_q  <= crc_mode_d;
      crc_field_q <= crc_field_d;
      crc_err_q   <= crc_err_d;
`endif
      data_q      <= data_d;
      valid_q     <= valid_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // The start pulse is combinational so the baud generator can resync in
  // the same cycle; it stays quiet while reset is held.
  assign sampled_start_o = start_hit & rst_ni;
  assign busy_o          = (state_q != IDLE);
  assign data_o          = data_q;
  assign data_valid_o    = valid_q;
  assign parity_err_o    = par_err_q;
  assign frame_err_o     = frame_err_q;
  assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_uart_rx_frame_path.sv
// tb_uart_rx_frame_path
//   Directed and randomised frames for uart_rx_frame_path (DATA_W=8,
//   STOP_BITS=1, CRC-8 poly 0x07 seed 0x00). Works with or without
//   UART_RX_CRC_EN; without it the CRC request is ignored and crc_err_o must
//   stay low.
module tb_uart_rx_frame_path;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       rx_i;
  logic       trigger_i;
  logic [1:0] parity_mode_i;
  logic       crc_en_i;
  logic       sampled_start_o;
  logic       busy_o;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       data_ready_i;
  logic       parity_err_o;
  logic       crc_err_o;
  logic       frame_err_o;
  logic       overrun_o;

  int vectors     = 0;
  int miscompares = 0;

  // Expected state of the output word port.
  logic [7:0] exp_data;
  logic       exp_valid;

`ifdef UART_RX_CRC_EN
  localparam bit CRC_BUILT = 1'b1;
`else
  localparam bit CRC_BUILT = 1'b0;
`endif

  uart_rx_frame_path #(
    .DATA_W    (8),
    .STOP_BITS (1),
    .CRC_W     (8),
    .CRC_POLY  (8'h07),
    .CRC_INIT  (8'h00)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .rx_i            (rx_i),
    .trigger_i       (trigger_i),
    .parity_mode_i   (parity_mode_i),
    .crc_en_i        (crc_en_i),
    .sampled_start_o (sampled_start_o),
    .busy_o          (busy_o),
    .data_o          (data_o),
    .data_valid_o    (data_valid_o),
    .data_ready_i    (data_ready_i),
    .parity_err_o    (parity_err_o),
    .crc_err_o       (crc_err_o),
    .frame_err_o     (frame_err_o),
    .overrun_o       (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // CRC-8 of the data bits taken in line order (LSB first).
  function automatic logic [7:0] crc_ref(input logic [7:0] data);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < 8; i++) begin
      fb = c[7] ^ data[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  // Present one line sample with a strobe; called and returns on a negedge.
  task automatic apply_stimulus(input logic b);
    rx_i      = b;
    trigger_i = 1'b1;
    @(negedge clk_i);
    trigger_i = 1'b0;
  endtask

  task automatic check_all_quiet(input string tag);
    check_output({tag, " parity_err"}, parity_err_o, 1'b0);
    check_output({tag, " crc_err"}, crc_err_o, 1'b0);
    check_output({tag, " frame_err"}, frame_err_o, 1'b0);
    check_output({tag, " overrun"}, overrun_o, 1'b0);
  endtask

  // Send a whole frame and check the outcome against the frame rules.
  task automatic send_frame(input string tag, input logic [7:0] data, input logic [1:0] mode,
                            input logic crc_req, input logic [7:0] crc_field, input logic par_flip,
                            input logic stop_val, input logic ready_mid, input logic ready_last);
    logic crc_on, par_on, par_bit, good;
    logic exp_par, exp_crc, exp_frame, exp_ovr;

    crc_on    = crc_req & CRC_BUILT;
    par_on    = !crc_on && (mode == 2'd1 || mode == 2'd2);
    // Even mode: total ones even; odd mode: total ones odd.
    par_bit   = (($countones(data) % 2) == 1) ^ (mode == 2'd2) ^ par_flip;
    exp_par   = par_on && par_flip;
    exp_crc   = crc_on && (crc_field != crc_ref(data));
    exp_frame = !stop_val;
    good      = !(exp_par || exp_crc || exp_frame);

    parity_mode_i = mode;
    crc_en_i      = crc_req;
    data_ready_i  = ready_mid;
    if (ready_mid) exp_valid = 1'b0;

    apply_stimulus(1'b1);
    check_output({tag, " idle busy"}, busy_o, 1'b0);

    rx_i      = 1'b0;
    trigger_i = 1'b1;
    #1;
    check_output({tag, " start pulse"}, sampled_start_o, 1'b1);
    @(negedge clk_i);
    trigger_i = 1'b0;
    check_output({tag, " busy"}, busy_o, 1'b1);

    // Mid-frame configuration changes must not affect this frame.
    parity_mode_i = 2'($urandom);
    crc_en_i      = 1'($urandom);

    for (int i = 0; i < 8; i++) begin
      repeat (3) @(negedge clk_i);
      apply_stimulus(data[i]);
    end
    if (crc_on) begin
      for (int i = 0; i < 8; i++) begin
        repeat (3) @(negedge clk_i);
        apply_stimulus(crc_field[i]);
      end
    end else if (par_on) begin
      repeat (3) @(negedge clk_i);
      apply_stimulus(par_bit);
    end
    repeat (3) @(negedge clk_i);
    check_output({tag, " valid before stop"}, data_valid_o, exp_valid);

    data_ready_i = ready_last;
    apply_stimulus(stop_val);

    exp_ovr = 1'b0;
    if (good) begin
      if (exp_valid && !ready_last) begin
        exp_ovr = 1'b1;
      end else begin
        exp_data  = data;
        exp_valid = 1'b1;
      end
    end else if (ready_last) begin
      exp_valid = 1'b0;
    end

    check_output({tag, " busy end"}, busy_o, 1'b0);
    check_output({tag, " valid"}, data_valid_o, exp_valid);
    check_output({tag, " data"}, data_o, exp_data);
    check_output({tag, " parity_err"}, parity_err_o, exp_par);
    check_output({tag, " crc_err"}, crc_err_o, exp_crc);
    check_output({tag, " frame_err"}, frame_err_o, exp_frame);
    check_output({tag, " overrun"}, overrun_o, exp_ovr);
    data_ready_i = 1'b0;

    @(negedge clk_i);
    check_all_quiet({tag, " after"});
    check_output({tag, " valid hold"}, data_valid_o, exp_valid);
    rx_i = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    rst_ni        = 1'b0;
    rx_i          = 1'b1;
    trigger_i     = 1'b0;
    parity_mode_i = 2'd0;
    crc_en_i      = 1'b0;
    data_ready_i  = 1'b0;
    exp_data      = 8'h00;
    exp_valid     = 1'b0;

    repeat (3) @(negedge clk_i);
    check_output("reset busy", busy_o, 1'b0);
    check_output("reset valid", data_valid_o, 1'b0);
    check_output("reset data", data_o, 8'h00);
    check_output("reset start", sampled_start_o, 1'b0);
    check_all_quiet("reset");
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    $display("[TB] directed frames");
    send_frame("par_even",      8'hA5, 2'd1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame("par_odd",       8'hA5, 2'd2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame("crc_ok",        8'h01, 2'd0, 1'b1, 8'h89, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame("crc_bad",       8'h01, 2'd0, 1'b1, 8'h88, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame("stop_err",      8'h3C, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame("after_ferr",    8'h5A, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame("ovr_first",     8'h11, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame("ovr_second",    8'h22, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame("ready_resolve", 8'h22, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame("par_rsvd",      8'hC3, 2'd3, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("[TB] reset in the middle of a frame");
    parity_mode_i = 2'd0;
    apply_stimulus(1'b0);
    repeat (3) @(negedge clk_i);
    apply_stimulus(1'b1);
    repeat (3) @(negedge clk_i);
    apply_stimulus(1'b0);
    check_output("midreset busy before", busy_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    check_output("midreset busy", busy_o, 1'b0);
    check_output("midreset valid", data_valid_o, 1'b0);
    check_output("midreset data", data_o, 8'h00);
    check_output("midreset start", sampled_start_o, 1'b0);
    check_all_quiet("midreset");
    exp_data  = 8'h00;
    exp_valid = 1'b0;
    rx_i      = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    send_frame("post_reset", 8'h7E, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("[TB] random frames");
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic [7:0] f;
      logic [1:0] m;
      logic       c, fl, st, rm, rl;
      d  = 8'($urandom);
      m  = 2'($urandom);
      c  = 1'($urandom);
      f  = ($urandom_range(0, 1) == 1) ? crc_ref(d) : 8'($urandom);
      fl = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 4) != 0);
      rm = 1'($urandom);
      rl = 1'($urandom);
      send_frame($sformatf("rnd%0d", n), d, m, c, f, fl, st, rm, rl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
